// File: rtl/risc_pkg.sv
// Shared definitions for the RISC core: opcodes, controller state encoding,
// bus widths and the registered control-strobe bundle.
package risc_pkg;

    localparam int RISC_ADDR_W = 13;
    localparam int RISC_DATA_W = 8;

    localparam logic [2:0] OP_HLT = 3'b000;
    localparam logic [2:0] OP_SKZ = 3'b001;
    localparam logic [2:0] OP_ADD = 3'b010;
    localparam logic [2:0] OP_AND = 3'b011;
    localparam logic [2:0] OP_XOR = 3'b100;
    localparam logic [2:0] OP_LDA = 3'b101;
    localparam logic [2:0] OP_STO = 3'b110;
    localparam logic [2:0] OP_JMP = 3'b111;

    typedef enum logic [3:0] {
        ST_IDLE = 4'd0,
        ST_F_HI = 4'd1,
        ST_INC1 = 4'd2,
        ST_F_LO = 4'd3,
        ST_DEC  = 4'd4,
        ST_EX1  = 4'd5,
        ST_EX2  = 4'd6,
        ST_EX3  = 4'd7,
        ST_EX4  = 4'd8,
        ST_HALT = 4'd9
    } ctrl_state_e;

    typedef struct packed {
        logic inc_pc;
        logic load_pc;
        logic load_ir;
        logic ir_byte_sel;
        logic rd;
        logic wr;
        logic load_acc;
        logic datactl_ena;
        logic halt;
    } ctrl_out_t;

    function automatic logic is_alu_op(input logic [2:0] op);
        return (op == OP_ADD) || (op == OP_AND) || (op == OP_XOR) || (op == OP_LDA);
    endfunction

endpackage

// File: rtl/risc_ctrl_fsm_if.sv
// Controller-side bundle: status inputs from the datapath and the
// control strobes the sequencer drives back into it.
interface risc_ctrl_fsm_if;
    logic        ena;
    logic [2:0]  opcode;
    logic        zero;
    logic        inc_pc;
    logic        load_pc;
    logic        load_ir;
    logic        ir_byte_sel;
    logic        rd;
    logic        wr;
    logic        load_acc;
    logic        datactl_ena;
    logic        halt;
    logic [31:0] instr_cnt;

    modport master (
        input  ena, opcode, zero,
        output inc_pc, load_pc, load_ir, ir_byte_sel, rd, wr,
               load_acc, datactl_ena, halt, instr_cnt
    );

    modport slave (
        output ena, opcode, zero,
        input  inc_pc, load_pc, load_ir, ir_byte_sel, rd, wr,
               load_acc, datactl_ena, halt, instr_cnt
    );
endinterface

// File: rtl/risc_ctrl_fsm.sv
// 8-cycle fetch/decode/execute sequencer with fully registered strobes.
// Define RISC_CTRL_INSTR_CNT_EN to build the retired-instruction counter.
module risc_ctrl_fsm
    import risc_pkg::*;
(
    input  logic             clk_ctrl,
    input  logic             reset,
    risc_ctrl_fsm_if.master  bus
);

    ctrl_state_e state_q, state_d;
    logic [2:0]  op_q;
    logic        zero_q;
    ctrl_out_t   out_q, out_d;
    logic [2:0]  op_eff;
    logic        zero_eff;

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: if (bus.ena) state_d = ST_F_HI;
            ST_F_HI: state_d = ST_INC1;
            ST_INC1: state_d = ST_F_LO;
            ST_F_LO: state_d = ST_DEC;
            ST_DEC:  state_d = (op_q == OP_HLT) ? ST_HALT : ST_EX1;
            ST_EX1:  state_d = ST_EX2;
            ST_EX2:  state_d = ST_EX3;
            ST_EX3:  state_d = ST_EX4;
            ST_EX4:  state_d = bus.ena ? ST_F_HI : ST_IDLE;
            ST_HALT: state_d = ST_HALT;
            default: state_d = ST_IDLE;
        endcase
    end

    // Outputs are registered from the next state, so opcode/zero must be taken
    // from the inputs on the very edge that latches them.
    always_comb begin
        out_d    = '0;
        op_eff   = (state_q == ST_F_LO) ? bus.opcode : op_q;
        zero_eff = (state_q == ST_EX1) ? bus.zero : zero_q;
        unique case (state_d)
            ST_F_HI: begin
                out_d.rd      = 1'b1;
                out_d.load_ir = 1'b1;
            end
            ST_INC1: out_d.inc_pc = 1'b1;
            ST_F_LO: begin
                out_d.rd          = 1'b1;
                out_d.load_ir     = 1'b1;
                out_d.ir_byte_sel = 1'b1;
            end
            ST_DEC:  out_d.inc_pc = (op_eff != OP_HLT);
            ST_EX1: begin
                out_d.rd          = is_alu_op(op_eff);
                out_d.datactl_ena = (op_eff == OP_STO);
                out_d.load_pc     = (op_eff == OP_JMP);
            end
            ST_EX2: begin
                out_d.rd          = is_alu_op(op_eff);
                out_d.load_acc    = is_alu_op(op_eff);
                out_d.datactl_ena = (op_eff == OP_STO);
                out_d.wr          = (op_eff == OP_STO);
                out_d.load_pc     = (op_eff == OP_JMP);
                out_d.inc_pc      = (op_eff == OP_JMP) || ((op_eff == OP_SKZ) && zero_eff);
            end
            ST_EX3: begin
                out_d.rd          = is_alu_op(op_eff);
                out_d.datactl_ena = (op_eff == OP_STO);
            end
            ST_EX4:  out_d.inc_pc = (op_eff == OP_SKZ) && zero_eff;
            ST_HALT: out_d.halt = 1'b1;
            default: out_d = '0;
        endcase
    end

    always_ff @(posedge clk_ctrl) begin
        if (reset) begin
            state_q <= ST_IDLE;
            op_q    <= OP_HLT;
            zero_q  <= 1'b0;
            out_q   <= '0;
        end else begin
            state_q <= state_d;
            out_q   <= out_d;
            if (state_q == ST_F_LO) op_q   <= bus.opcode;
            if (state_q == ST_EX1)  zero_q <= bus.zero;
        end
    end

    assign bus.inc_pc      = out_q.inc_pc;
    assign bus.load_pc     = out_q.load_pc;
    assign bus.load_ir     = out_q.load_ir;
    assign bus.ir_byte_sel = out_q.ir_byte_sel;
    assign bus.rd          = out_q.rd;
    assign bus.wr          = out_q.wr;
    assign bus.load_acc    = out_q.load_acc;
    assign bus.datactl_ena = out_q.datactl_ena;
    assign bus.halt        = out_q.halt;

`ifdef RISC_CTRL_INSTR_CNT_EN
    logic [31:0] instr_cnt_q;

    always_ff @(posedge clk_ctrl) begin
        if (reset) begin
            instr_cnt_q <= '0;
        end else if (state_q == ST_EX4) begin
            instr_cnt_q <= instr_cnt_q + 32'd1;
        end
    end

    assign bus.instr_cnt = instr_cnt_q;
`else
    assign bus.instr_cnt = '0;
`endif

endmodule
